df_tap_accumulator: RTL and testbench
=====================================

# df_tap_accumulator

Sequential accumulation stage that drives the 9-bit two's-complement adder/subtractor of the digital filter and consumes its result. It accepts NUM_TAPS signed products per frame over a valid/ready handshake and adds or subtracts each one into a 9-bit running sum through the external adder. After the last tap it presents the frame sum with an overflow flag to the downstream stage. It sits between the tap/coefficient product source and the filter output register.

## Interface
- NUM_TAPS, 4, taps per frame; legal range 1..256.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream tap valid.
- in_ready  output  1  block accepts a tap this cycle.
- in_data  input  9  signed tap value.
- in_sub  input  1  1 = subtract in_data from the sum, 0 = add it.
- add_a  output  9  adder operand a; equals the accumulator register.
- add_b  output  9  adder operand b; equals in_data, unregistered.
- add_sub  output  1  adder sub control; equals in_sub, unregistered.
- add_out  input  9  combinational adder result a ± b; carry out is not used.
- out_valid  output  1  frame sum valid.
- out_ready  input  1  downstream accepts the sum.
- out_data  output  9  signed frame sum, registered.
- out_ovf  output  1  at least one step of this frame overflowed; registered.

## Operation
- States: ACC and DONE. Reset state is ACC.
- Internal registers:
  - acc[8:0], the running sum.
  - cnt, the tap index, ceil(log2(NUM_TAPS)) bits, minimum 1.
  - ovf, a sticky overflow flag.
- in_ready = (state == ACC) and not rst.
- ACC state:
  - A tap is accepted on in_valid & in_ready. On accept, acc <= step result, ovf <= ovf | step_ovf, and cnt increments.
  - If cnt == NUM_TAPS-1 at accept, the following happen together: out_data <= step result, out_ovf <= ovf | step_ovf, out_valid <= 1, and the state goes to DONE.
- DONE state:
  - in_ready = 0; out_data and out_ovf are held.
  - On out_valid & out_ready: out_valid <= 0, acc <= 0, cnt <= 0, ovf <= 0, and the state goes to ACC.
- Step overflow rules:
  - Add: step_ovf = (acc[8] == in_data[8]) & (add_out[8] != acc[8]).
  - Subtract: step_ovf = (acc[8] != in_data[8]) & (add_out[8] != acc[8]).
- Arithmetic is 9-bit two's complement, range -256..255.
- When in_valid is low, add_b and add_sub still follow in_data and in_sub. add_out is ignored unless a tap is accepted.
- NUM_TAPS = 1: every accepted tap goes directly to DONE.

## Timing
- Reset values:
  - state = ACC; acc, cnt, out_data = 0; out_valid, out_ovf, ovf = 0.
  - in_ready = 0 while rst = 1 and 1 in the first cycle after release.
- Reset mid-frame or in DONE discards the partial sum and any pending output. The block returns to reset values on the next edge.
- One tap is accepted per cycle, with no bubbles while in_valid stays high.
- Latency: out_valid rises on the edge that accepts the last tap.
- Throughput: minimum NUM_TAPS+1 cycles per frame. DONE lasts at least one cycle, even when out_ready is already high.
- No tap is accepted in the cycle of the output handshake. The first tap of the next frame is accepted one cycle later, at the earliest.
- While out_valid = 1, out_data and out_ovf stay stable until the handshake.

## Configuration
- DF_ACC_SATURATE_EN:
  - Defined: the step result saturates on overflow. It becomes 9'h0FF when acc[8] = 0 and 9'h100 when acc[8] = 1; otherwise it is add_out.
  - Undefined: the step result is always add_out, and sums wrap modulo 512.
- out_ovf is reported identically in both builds.

## Test plan
- Reset, then NUM_TAPS = 4, taps +10, +20, -5 (sub = 1), +3 with in_valid held high.
  - in_ready is high for 4 consecutive cycles.
  - out_valid rises after the 4th accept with out_data = 28 and out_ovf = 0.
  - in_ready = 0 until out_ready.
- Taps 200, 100 (add), 0, 0.
  - With the macro: out_data = 255, out_ovf = 1.
  - Without the macro: out_data = 300 - 512 = -212 (9'h12C), out_ovf = 1.
- Taps 0 minus (-256), then +0 three times.
  - Overflow is flagged.
  - Saturated build: out_data = 255. Wrapping build: out_data = -256.
- Hold out_ready low for 5 cycles after out_valid while in_valid stays high.
  - out_data and out_valid are stable and no taps are accepted.
  - After the handshake, the next frame starts from acc = 0.
- Assert rst for one cycle after 2 of 4 taps.
  - All outputs go to reset values.
  - The next 4 taps 1, 1, 1, 1 produce out_data = 4.
- NUM_TAPS = 1, taps 7 then 9 with out_ready held high.
  - Outputs 7 and 9, each appearing one cycle after its accept.
  - Accepts are spaced 2 cycles apart.

Source files
------------

// File: rtl/df_tap_accumulator.sv
// rtl/df_tap_accumulator.sv - frame tap accumulator driving an external 9-bit add/sub; optional DF_ACC_SATURATE_EN
module df_tap_accumulator #(
    parameter int NUM_TAPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_data,
    input  logic       in_sub,
    output logic [8:0] add_a,
    output logic [8:0] add_b,
    output logic       add_sub,
    input  logic [8:0] add_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_data,
    output logic       out_ovf
);

    localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t           state;
    logic [8:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             same_sign;
    logic             step_ovf;
    logic [8:0]       step_result;

    assign in_ready = (state == S_ACC) && !rst;
    assign accept   = in_valid && in_ready;

    // The adder operands are passed straight through so the external adder sees this cycle's tap.
    assign add_a   = acc;
    assign add_b   = in_data;
    assign add_sub = in_sub;

    // Subtracting flips the effective sign of b, so the sign-agreement test inverts.
    assign same_sign = (acc[8] == in_data[8]);
    assign step_ovf  = (in_sub ? !same_sign : same_sign) && (add_out[8] != acc[8]);

`ifdef DF_ACC_SATURATE_EN
    assign step_result = step_ovf ? (acc[8] ? 9'h100 : 9'h0FF) : add_out;
`else
    assign step_result = add_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (accept) begin
                        acc <= step_result;
                        ovf <= ovf | step_ovf;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_TAP) begin
                            out_data  <= step_result;
                            out_ovf   <= ovf | step_ovf;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Output stays frozen until consumed; the frame state is cleared on the handshake.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        state     <= S_ACC;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_df_tap_accumulator.sv
// tb/tb_df_tap_accumulator.sv - directed bench for df_tap_accumulator (NUM_TAPS 4 and 1)
module tb_df_tap_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid4, in_ready4, in_sub4, add_sub4, out_valid4, out_ready4, out_ovf4;
    logic [8:0] in_data4, add_a4, add_b4, add_out4, out_data4;
    logic       in_valid1, in_ready1, in_sub1, add_sub1, out_valid1, out_ready1, out_ovf1;
    logic [8:0] in_data1, add_a1, add_b1, add_out1, out_data1;

    assign add_out4 = add_sub4 ? (add_a4 - add_b4) : (add_a4 + add_b4);
    assign add_out1 = add_sub1 ? (add_a1 - add_b1) : (add_a1 + add_b1);

    df_tap_accumulator #(.NUM_TAPS(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_sub(in_sub4),
        .add_a(add_a4), .add_b(add_b4), .add_sub(add_sub4), .add_out(add_out4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_ovf(out_ovf4)
    );

    df_tap_accumulator #(.NUM_TAPS(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_sub(in_sub1),
        .add_a(add_a1), .add_b(add_b1), .add_sub(add_sub1), .add_out(add_out1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_ovf(out_ovf1)
    );

`ifdef DF_ACC_SATURATE_EN
    localparam logic [8:0] EXP_POS_OVF = 9'h0FF;
    localparam logic [8:0] EXP_NEG_SUB = 9'h0FF;
`else
    localparam logic [8:0] EXP_POS_OVF = 9'h12C;
    localparam logic [8:0] EXP_NEG_SUB = 9'h100;
`endif

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tap4(input logic [8:0] d, input logic s, input string tag);
        in_valid4 = 1'b1;
        in_data4  = d;
        in_sub4   = s;
        #1;
        chk(tag, in_ready4, 1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        in_valid4 = 0; in_data4 = 0; in_sub4 = 0; out_ready4 = 0;
        in_valid1 = 0; in_data1 = 0; in_sub1 = 0; out_ready1 = 0;
        tick();
        tick();
        chk("rst_in_ready", in_ready4, 0);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_out_data", out_data4, 0);
        chk("rst_out_ovf", out_ovf4, 0);
        chk("rst_acc", add_a4, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready4, 1);

        // Frame 1: 10 + 20 - 5 + 3 = 28
        tap4(9'd10, 0, "f1_rdy0");
        tap4(9'd20, 0, "f1_rdy1");
        tap4(9'd5,  1, "f1_rdy2");
        tap4(9'd3,  0, "f1_rdy3");
        chk("f1_out_valid", out_valid4, 1);
        chk("f1_out_data", out_data4, 28);
        chk("f1_out_ovf", out_ovf4, 0);
        in_data4 = 9'd50;
        chk("f1_done_in_ready", in_ready4, 0);
        tick();
        chk("f1_done_in_ready2", in_ready4, 0);
        chk("f1_held_data", out_data4, 28);
        out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        out_ready4 = 1'b0;
        chk("f1_hs_out_valid", out_valid4, 0);
        chk("f1_hs_acc_clear", add_a4, 0);
        chk("f1_hs_in_ready", in_ready4, 1);

        // Frame 2: 200 + 100 overflows positive
        tap4(9'd200, 0, "f2_rdy0");
        tap4(9'd100, 0, "f2_rdy1");
        tap4(9'd0,   0, "f2_rdy2");
        tap4(9'd0,   0, "f2_rdy3");
        chk("f2_out_valid", out_valid4, 1);
        chk("f2_out_data", out_data4, EXP_POS_OVF);
        chk("f2_out_ovf", out_ovf4, 1);

        // Backpressure for 5 cycles with upstream still offering taps
        in_data4 = 9'd77;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready4, 0);
            tick();
            chk("bp_out_valid", out_valid4, 1);
            chk("bp_out_data", out_data4, EXP_POS_OVF);
        end
        out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        out_ready4 = 1'b0;
        chk("f2_hs_out_valid", out_valid4, 0);
        chk("f2_hs_acc_clear", add_a4, 0);

        // Frame 3: 0 - (-256) overflows
        tap4(9'h100, 1, "f3_rdy0");
        tap4(9'd0,   0, "f3_rdy1");
        tap4(9'd0,   0, "f3_rdy2");
        tap4(9'd0,   0, "f3_rdy3");
        chk("f3_out_valid", out_valid4, 1);
        chk("f3_out_data", out_data4, EXP_NEG_SUB);
        chk("f3_out_ovf", out_ovf4, 1);
        out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        out_ready4 = 1'b0;

        // Reset after 2 of 4 taps
        tap4(9'd5, 0, "f4_rdy0");
        tap4(9'd5, 0, "f4_rdy1");
        in_valid4 = 1'b0;
        chk("f4_partial_acc", add_a4, 10);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready4, 0);
        tick();
        rst = 1'b0;
        chk("mid_rst_acc", add_a4, 0);
        chk("mid_rst_out_data", out_data4, 0);
        chk("mid_rst_out_valid", out_valid4, 0);
        chk("mid_rst_out_ovf", out_ovf4, 0);
        tap4(9'd1, 0, "f5_rdy0");
        tap4(9'd1, 0, "f5_rdy1");
        tap4(9'd1, 0, "f5_rdy2");
        tap4(9'd1, 0, "f5_rdy3");
        in_valid4 = 1'b0;
        chk("f5_out_valid", out_valid4, 1);
        chk("f5_out_data", out_data4, 4);
        chk("f5_out_ovf", out_ovf4, 0);

        // NUM_TAPS = 1: taps 7 then 9, accepts two cycles apart
        in_valid1 = 1'b1;
        in_data1 = 9'd7;
        out_ready1 = 1'b1;
        #1;
        chk("n1_rdy_a", in_ready1, 1);
        tick();
        chk("n1_valid_a", out_valid1, 1);
        chk("n1_data_a", out_data1, 7);
        chk("n1_busy_a", in_ready1, 0);
        in_data1 = 9'd9;
        tick();
        chk("n1_hs_valid", out_valid1, 0);
        chk("n1_rdy_b", in_ready1, 1);
        tick();
        chk("n1_valid_b", out_valid1, 1);
        chk("n1_data_b", out_data1, 9);
        in_valid1 = 1'b0;
        tick();
        chk("n1_hs_valid_b", out_valid1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
